// File: rtl/loop_issue_unit.sv
// Expands a two-level loop descriptor into one queue push per cycle with
// incrementally strided cache and main-memory addresses.
module loop_issue_unit #(
  parameter int ADDR_W = 18,
  parameter int CNT_W  = 8,
  parameter int OP_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [1:0]        desc_type,
  input  logic [OP_W-1:0]   desc_op,
  input  logic [ADDR_W-1:0] desc_cache_base,
  input  logic [ADDR_W-1:0] desc_mem_base,
  input  logic [ADDR_W-1:0] desc_cache_stride_i,
  input  logic [ADDR_W-1:0] desc_cache_stride_j,
  input  logic [ADDR_W-1:0] desc_mem_stride_i,
  input  logic [ADDR_W-1:0] desc_mem_stride_j,
  input  logic [CNT_W-1:0]  desc_count_i,
  input  logic [CNT_W-1:0]  desc_count_j,
  input  logic              queue_full,
  output logic              queue_we,
  output logic [1:0]        queue_instr_type,
  output logic [OP_W-1:0]   queue_op,
  output logic [ADDR_W-1:0] queue_cache_addr,
  output logic [ADDR_W-1:0] queue_main_mem_addr,
  output logic              busy,
  output logic [15:0]       issued_count
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          type_q, type_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [ADDR_W-1:0]   cache_addr_q, cache_addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]   cache_row_q, cache_row_d;
  logic [ADDR_W-1:0]   mem_row_q, mem_row_d;
  logic [ADDR_W-1:0]   cache_si_q, cache_si_d;
  logic [ADDR_W-1:0]   cache_sj_q, cache_sj_d;
  logic [ADDR_W-1:0]   mem_si_q, mem_si_d;
  logic [ADDR_W-1:0]   mem_sj_q, mem_sj_d;
  logic [CNT_W-1:0]    count_i_q, count_i_d;
  logic [CNT_W-1:0]    count_j_q, count_j_d;
  logic [CNT_W-1:0]    i_q, i_d;
  logic [CNT_W-1:0]    j_q, j_d;
  logic [15:0]         issued_q, issued_d;
  logic                last_j, last_i;

  assign desc_ready          = (state_q == IDLE);
  assign busy                = (state_q == ISSUE);
  assign queue_we            = (state_q == ISSUE) && !queue_full;
  assign queue_instr_type    = type_q;
  assign queue_op            = op_q;
  assign queue_cache_addr    = cache_addr_q;
  assign queue_main_mem_addr = mem_addr_q;
  assign issued_count        = issued_q;

  assign last_j = (j_q == count_j_q - CNT_W'(1));
  assign last_i = (i_q == count_i_q - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    op_d         = op_q;
    cache_addr_d = cache_addr_q;
    mem_addr_d   = mem_addr_q;
    cache_row_d  = cache_row_q;
    mem_row_d    = mem_row_q;
    cache_si_d   = cache_si_q;
    cache_sj_d   = cache_sj_q;
    mem_si_d     = mem_si_q;
    mem_sj_d     = mem_sj_q;
    count_i_d    = count_i_q;
    count_j_d    = count_j_q;
    i_d          = i_q;
    j_d          = j_q;
    issued_d     = issued_q;

    case (state_q)
      IDLE: begin
        if (desc_valid) begin
          type_d       = desc_type;
          op_d         = desc_op;
          cache_addr_d = desc_cache_base;
          mem_addr_d   = desc_mem_base;
          cache_row_d  = desc_cache_base;
          mem_row_d    = desc_mem_base;
          cache_si_d   = desc_cache_stride_i;
          cache_sj_d   = desc_cache_stride_j;
          mem_si_d     = desc_mem_stride_i;
          mem_sj_d     = desc_mem_stride_j;
          count_i_d    = desc_count_i;
          count_j_d    = desc_count_j;
          i_d          = '0;
          j_d          = '0;
          // A zero trip count consumes the descriptor without issuing anything.
          if (desc_count_i != '0 && desc_count_j != '0)
            state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!queue_full) begin
          if (!last_j) begin
            j_d          = j_q + CNT_W'(1);
            cache_addr_d = cache_addr_q + cache_sj_q;
            mem_addr_d   = mem_addr_q + mem_sj_q;
          end else begin
            j_d          = '0;
            i_d          = i_q + CNT_W'(1);
            cache_row_d  = cache_row_q + cache_si_q;
            mem_row_d    = mem_row_q + mem_si_q;
            cache_addr_d = cache_row_q + cache_si_q;
            mem_addr_d   = mem_row_q + mem_si_q;
            if (last_i)
              state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (queue_we && issued_q != 16'hFFFF)
      issued_d = issued_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      type_q       <= '0;
      op_q         <= '0;
      cache_addr_q <= '0;
      mem_addr_q   <= '0;
      cache_row_q  <= '0;
      mem_row_q    <= '0;
      cache_si_q   <= '0;
      cache_sj_q   <= '0;
      mem_si_q     <= '0;
      mem_sj_q     <= '0;
      count_i_q    <= '0;
      count_j_q    <= '0;
      i_q          <= '0;
      j_q          <= '0;
      issued_q     <= '0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      op_q         <= op_d;
      cache_addr_q <= cache_addr_d;
      mem_addr_q   <= mem_addr_d;
      cache_row_q  <= cache_row_d;
      mem_row_q    <= mem_row_d;
      cache_si_q   <= cache_si_d;
      cache_sj_q   <= cache_sj_d;
      mem_si_q     <= mem_si_d;
      mem_sj_q     <= mem_sj_d;
      count_i_q    <= count_i_d;
      count_j_q    <= count_j_d;
      i_q          <= i_d;
      j_q          <= j_d;
      issued_q     <= issued_d;
    end
  end

endmodule

// File: tb/tb_loop_issue_unit.sv
// Directed bench for loop_issue_unit: one task per scenario with inline checks
// against hand-computed push sequences.
module tb_loop_issue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        desc_valid;
  logic        desc_ready;
  logic [1:0]  desc_type;
  logic [8:0]  desc_op;
  logic [17:0] desc_cache_base, desc_mem_base;
  logic [17:0] desc_cache_stride_i, desc_cache_stride_j;
  logic [17:0] desc_mem_stride_i, desc_mem_stride_j;
  logic [7:0]  desc_count_i, desc_count_j;
  logic        queue_full;
  logic        queue_we;
  logic [1:0]  queue_instr_type;
  logic [8:0]  queue_op;
  logic [17:0] queue_cache_addr, queue_main_mem_addr;
  logic        busy;
  logic [15:0] issued_count;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_issued = 16'd0;

  always #5 clk = ~clk;

  loop_issue_unit #(.ADDR_W(18), .CNT_W(8), .OP_W(9)) dut (
    .clk                 (clk),
    .reset               (reset),
    .desc_valid          (desc_valid),
    .desc_ready          (desc_ready),
    .desc_type           (desc_type),
    .desc_op             (desc_op),
    .desc_cache_base     (desc_cache_base),
    .desc_mem_base       (desc_mem_base),
    .desc_cache_stride_i (desc_cache_stride_i),
    .desc_cache_stride_j (desc_cache_stride_j),
    .desc_mem_stride_i   (desc_mem_stride_i),
    .desc_mem_stride_j   (desc_mem_stride_j),
    .desc_count_i        (desc_count_i),
    .desc_count_j        (desc_count_j),
    .queue_full          (queue_full),
    .queue_we            (queue_we),
    .queue_instr_type    (queue_instr_type),
    .queue_op            (queue_op),
    .queue_cache_addr    (queue_cache_addr),
    .queue_main_mem_addr (queue_main_mem_addr),
    .busy                (busy),
    .issued_count        (issued_count)
  );

  task automatic set_desc(input logic [1:0] t, input logic [8:0] op,
                          input logic [17:0] cb, input logic [17:0] csi, input logic [17:0] csj,
                          input logic [17:0] mb, input logic [17:0] msi, input logic [17:0] msj,
                          input logic [7:0] ci, input logic [7:0] cj);
    desc_type           = t;
    desc_op             = op;
    desc_cache_base     = cb;
    desc_cache_stride_i = csi;
    desc_cache_stride_j = csj;
    desc_mem_base       = mb;
    desc_mem_stride_i   = msi;
    desc_mem_stride_j   = msj;
    desc_count_i        = ci;
    desc_count_j        = cj;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      if (r == 1) reset = 1'b1;
      #1;
      total++; if (desc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d] got=%0b want=1", r, desc_ready); end
      total++; if (queue_we !== 1'b0) begin bad++; $display("FAIL reset_we[%0d] got=%0b want=0", r, queue_we); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%0b want=0", r, busy); end
      total++; if (issued_count !== 16'd0) begin bad++; $display("FAIL reset_issued[%0d] got=%0d want=0", r, issued_count); end
      total++; if (queue_cache_addr !== 18'h0 || queue_main_mem_addr !== 18'h0 || queue_op !== 9'h0)
        begin bad++; $display("FAIL reset_fields[%0d] got=%h/%h/%h want=0", r, queue_cache_addr, queue_main_mem_addr, queue_op); end
    end
  endtask

  task automatic test_basic;
    logic [17:0] exp_c [0:5];
    logic [17:0] exp_m [0:5];
    exp_c = '{18'h100, 18'h101, 18'h102, 18'h110, 18'h111, 18'h112};
    exp_m = '{18'h2000, 18'h2004, 18'h2008, 18'h2040, 18'h2044, 18'h2048};
    @(negedge clk);
    set_desc(2'd2, 9'h1A5, 18'h100, 18'h10, 18'h1, 18'h2000, 18'h40, 18'h4, 8'd2, 8'd3);
    desc_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      desc_valid = 1'b0;
      #1;
      total++; if (queue_we !== 1'b1 || busy !== 1'b1 || desc_ready !== 1'b0)
        begin bad++; $display("FAIL basic_we[%0d] got we=%0b busy=%0b rdy=%0b want 1,1,0", k, queue_we, busy, desc_ready); end
      total++; if (queue_cache_addr !== exp_c[k]) begin bad++; $display("FAIL basic_cache[%0d] got=%h want=%h", k, queue_cache_addr, exp_c[k]); end
      total++; if (queue_main_mem_addr !== exp_m[k]) begin bad++; $display("FAIL basic_mem[%0d] got=%h want=%h", k, queue_main_mem_addr, exp_m[k]); end
      total++; if (queue_instr_type !== 2'd2 || queue_op !== 9'h1A5)
        begin bad++; $display("FAIL basic_payload[%0d] got=%0d/%h want=2/1a5", k, queue_instr_type, queue_op); end
    end
    exp_issued = exp_issued + 16'd6;
    @(negedge clk); #1;
    total++; if (desc_ready !== 1'b1 || busy !== 1'b0 || queue_we !== 1'b0)
      begin bad++; $display("FAIL basic_done got rdy=%0b busy=%0b we=%0b want 1,0,0", desc_ready, busy, queue_we); end
    total++; if (issued_count !== exp_issued) begin bad++; $display("FAIL basic_issued got=%0d want=%0d", issued_count, exp_issued); end
  endtask

  task automatic test_backpressure;
    logic        full_pat [0:8];
    logic [17:0] exp_c    [0:8];
    logic [17:0] exp_m    [0:8];
    full_pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_c    = '{18'h100, 18'h101, 18'h102, 18'h102, 18'h102, 18'h102, 18'h110, 18'h111, 18'h112};
    exp_m    = '{18'h2000, 18'h2004, 18'h2008, 18'h2008, 18'h2008, 18'h2008, 18'h2040, 18'h2044, 18'h2048};
    @(negedge clk);
    set_desc(2'd1, 9'h033, 18'h100, 18'h10, 18'h1, 18'h2000, 18'h40, 18'h4, 8'd2, 8'd3);
    desc_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      desc_valid = 1'b0;
      queue_full = full_pat[c];
      #1;
      total++; if (queue_we !== !full_pat[c]) begin bad++; $display("FAIL bp_we[%0d] got=%0b want=%0b", c, queue_we, !full_pat[c]); end
      total++; if (queue_cache_addr !== exp_c[c]) begin bad++; $display("FAIL bp_cache[%0d] got=%h want=%h", c, queue_cache_addr, exp_c[c]); end
      total++; if (queue_main_mem_addr !== exp_m[c]) begin bad++; $display("FAIL bp_mem[%0d] got=%h want=%h", c, queue_main_mem_addr, exp_m[c]); end
    end
    exp_issued = exp_issued + 16'd6;
    @(negedge clk);
    queue_full = 1'b0;
    #1;
    total++; if (desc_ready !== 1'b1 || queue_we !== 1'b0) begin bad++; $display("FAIL bp_done got rdy=%0b we=%0b want 1,0", desc_ready, queue_we); end
    total++; if (issued_count !== exp_issued) begin bad++; $display("FAIL bp_issued got=%0d want=%0d", issued_count, exp_issued); end
  endtask

  task automatic test_zero_count;
    @(negedge clk);
    set_desc(2'd3, 9'h0FF, 18'h500, 18'h1, 18'h1, 18'h600, 18'h1, 18'h1, 8'd0, 8'd5);
    desc_valid = 1'b1;
    @(negedge clk);
    desc_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      total++; if (queue_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zero_we[%0d] got we=%0b busy=%0b want 0,0", c, queue_we, busy); end
      total++; if (desc_ready !== 1'b1) begin bad++; $display("FAIL zero_ready[%0d] got=%0b want=1", c, desc_ready); end
      total++; if (issued_count !== exp_issued) begin bad++; $display("FAIL zero_issued[%0d] got=%0d want=%0d", c, issued_count, exp_issued); end
    end
  endtask

  task automatic test_wrap;
    logic [17:0] exp_c [0:1];
    exp_c = '{18'h3FFFF, 18'h00001};
    @(negedge clk);
    set_desc(2'd0, 9'h001, 18'h3FFFF, 18'h0, 18'h2, 18'h3FFFE, 18'h0, 18'h3, 8'd1, 8'd2);
    desc_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      desc_valid = 1'b0;
      #1;
      total++; if (queue_we !== 1'b1) begin bad++; $display("FAIL wrap_we[%0d] got=%0b want=1", k, queue_we); end
      total++; if (queue_cache_addr !== exp_c[k]) begin bad++; $display("FAIL wrap_cache[%0d] got=%h want=%h", k, queue_cache_addr, exp_c[k]); end
    end
    total++; if (queue_main_mem_addr !== 18'h00001) begin bad++; $display("FAIL wrap_mem got=%h want=00001", queue_main_mem_addr); end
    exp_issued = exp_issued + 16'd2;
    @(negedge clk); #1;
    total++; if (desc_ready !== 1'b1 || queue_we !== 1'b0) begin bad++; $display("FAIL wrap_done got rdy=%0b we=%0b want 1,0", desc_ready, queue_we); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    set_desc(2'd2, 9'h010, 18'h100, 18'h10, 18'h1, 18'h2000, 18'h40, 18'h4, 8'd2, 8'd3);
    desc_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      desc_valid = 1'b0;
      #1;
      total++; if (queue_we !== 1'b1) begin bad++; $display("FAIL rmid_we[%0d] got=%0b want=1", k, queue_we); end
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_issued = 16'd0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      total++; if (queue_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_idle[%0d] got we=%0b busy=%0b want 0,0", c, queue_we, busy); end
      total++; if (desc_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready[%0d] got=%0b want=1", c, desc_ready); end
      total++; if (issued_count !== exp_issued) begin bad++; $display("FAIL rmid_issued[%0d] got=%0d want=%0d", c, issued_count, exp_issued); end
    end
  endtask

  task automatic test_back_to_back;
    logic        exp_we [0:5];
    logic        exp_rd [0:5];
    logic [17:0] exp_c  [0:5];
    logic [1:0]  exp_t  [0:5];
    exp_we = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_rd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_c  = '{18'h010, 18'h011, 18'h011, 18'h020, 18'h023, 18'h026};
    exp_t  = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3};
    @(negedge clk);
    set_desc(2'd1, 9'h011, 18'h010, 18'h0, 18'h1, 18'h800, 18'h0, 18'h8, 8'd1, 8'd2);
    desc_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) set_desc(2'd3, 9'h022, 18'h020, 18'h0, 18'h3, 18'h900, 18'h0, 18'h10, 8'd1, 8'd2);
      if (c == 3) desc_valid = 1'b0;
      #1;
      total++; if (queue_we !== exp_we[c]) begin bad++; $display("FAIL b2b_we[%0d] got=%0b want=%0b", c, queue_we, exp_we[c]); end
      total++; if (desc_ready !== exp_rd[c]) begin bad++; $display("FAIL b2b_ready[%0d] got=%0b want=%0b", c, desc_ready, exp_rd[c]); end
      if (exp_we[c]) begin
        total++; if (queue_cache_addr !== exp_c[c] || queue_instr_type !== exp_t[c])
          begin bad++; $display("FAIL b2b_push[%0d] got=%h/%0d want=%h/%0d", c, queue_cache_addr, queue_instr_type, exp_c[c], exp_t[c]); end
      end
    end
    exp_issued = exp_issued + 16'd4;
    total++; if (issued_count !== exp_issued) begin bad++; $display("FAIL b2b_issued got=%0d want=%0d", issued_count, exp_issued); end
  endtask

  initial begin
    desc_valid = 1'b0;
    queue_full = 1'b0;
    set_desc(2'd0, 9'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 8'd0, 8'd0);
    test_reset;
    test_basic;
    test_backpressure;
    test_zero_count;
    test_wrap;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

endmodule
